// File: rtl/instr_mem_loader_pkg.sv
// Shared definitions for the boot-time instruction memory loader.
//   - FSM state encoding (state_t plus S_* constants)
//   - BYTES_PER_WORD: bytes assembled into one instruction word
//   - CNT_W: width of the word-count header in the byte stream
//   - max_words(): largest legal word count for a given address width
package instr_mem_loader_pkg;

  localparam int BYTES_PER_WORD = 4;
  localparam int WORD_W         = BYTES_PER_WORD * 8;
  localparam int CNT_W          = 16;

  typedef logic [2:0] state_t;

  localparam state_t S_CNT_HI = 3'd0;
  localparam state_t S_CNT_LO = 3'd1;
  localparam state_t S_DATA   = 3'd2;
  localparam state_t S_WRITE  = 3'd3;
  localparam state_t S_DONE   = 3'd4;
  localparam state_t S_ERR    = 3'd5;

  // One bit wider than the count so that 2^ADDR_W (a legal, memory-filling
  // count) can be represented and compared without overflow.
  function automatic logic [CNT_W:0] max_words(input int addr_w);
    return (CNT_W + 1)'(1) << addr_w;
  endfunction

endpackage

// File: rtl/instr_mem_loader_word_assembler.sv
// word_assembler: collects four bytes, first byte most significant.
//   clock, reset_n : system clock, asynchronous active-low reset
//   clear          : restart at byte 0 (start of a new program body)
//   shift_en       : byte_in is taken this cycle
//   byte_in        : incoming byte
//   word           : completed big-endian word; valid while word_done is high
//   word_done      : the byte taken this cycle is the 4th of a word
module word_assembler
  import instr_mem_loader_pkg::*;
(
  input  logic              clock,
  input  logic              reset_n,
  input  logic              clear,
  input  logic              shift_en,
  input  logic [7:0]        byte_in,
  output logic [WORD_W-1:0] word,
  output logic              word_done
);

  // Only the first three bytes need storage; the fourth is combined
  // directly so the word is available in the cycle it arrives.
  logic [WORD_W-9:0] shift_reg;
  logic [1:0]        byte_cnt_reg;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      shift_reg    <= '0;
      byte_cnt_reg <= '0;
    end else if (clear) begin
      byte_cnt_reg <= '0;
    end else if (shift_en) begin
      shift_reg    <= {shift_reg[WORD_W-17:0], byte_in};
      byte_cnt_reg <= byte_cnt_reg + 2'd1;  // wraps 3 -> 0 at word end
    end
  end

  assign word      = {shift_reg, byte_in};
  assign word_done = shift_en && (byte_cnt_reg == 2'd3);

endmodule

// File: rtl/instr_mem_loader.sv
// instr_mem_loader: writes a program received as a byte stream into the
// instruction memory, holding the CPU stalled until the load completes.
// Stream: 16-bit big-endian word count N, then N big-endian 32-bit words.
//   clock, reset_n    : system clock, asynchronous active-low reset
//   rx_data/rx_valid  : incoming byte from the UART receiver
//   rx_ready          : byte accepted when rx_valid && rx_ready
//   load_req          : restart a load from S_DONE or S_ERR
//   mem_we/addr/din   : instruction memory write port (addr/din registered)
//   cpu_run           : program loaded, CPU may fetch
//   load_err          : word count exceeded memory size
module instr_mem_loader
  import instr_mem_loader_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  input  logic              load_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  output logic              cpu_run,
  output logic              load_err
);

  localparam logic [CNT_W:0] MAX_N = max_words(ADDR_W);

  state_t              state_reg, state_next;
  logic [7:0]          cnt_hi_reg;
  logic [CNT_W-1:0]    last_idx_reg;   // N-1, address of the final word
  logic [ADDR_W-1:0]   addr_reg;
  logic [ADDR_W-1:0]   mem_addr_reg;
  logic [DATA_W-1:0]   mem_din_reg;
  logic                cpu_run_reg;

  logic                xfer;
  logic [CNT_W-1:0]    count_in;
  logic                asm_clear;
  logic                asm_shift;
  logic [WORD_W-1:0]   asm_word;
  logic                asm_done;
  logic                is_last;

  assign xfer      = rx_valid && rx_ready;
  assign count_in  = {cnt_hi_reg, rx_data};
  assign asm_clear = xfer && (state_reg == S_CNT_LO);
  assign asm_shift = xfer && (state_reg == S_DATA);
  assign is_last   = (CNT_W'(addr_reg) == last_idx_reg);

  word_assembler u_word_assembler (
    .clock     (clock),
    .reset_n   (reset_n),
    .clear     (asm_clear),
    .shift_en  (asm_shift),
    .byte_in   (rx_data),
    .word      (asm_word),
    .word_done (asm_done)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_CNT_HI: if (xfer) state_next = S_CNT_LO;
      S_CNT_LO: begin
        if (xfer) begin
          if (count_in == '0)
            state_next = S_DONE;
          else if ({1'b0, count_in} > MAX_N)
            state_next = S_ERR;
          else
            state_next = S_DATA;
        end
      end
      S_DATA:   if (asm_done) state_next = S_WRITE;
      S_WRITE:  state_next = is_last ? S_DONE : S_DATA;
      S_DONE,
      S_ERR:    if (load_req) state_next = S_CNT_HI;
      default:  state_next = S_CNT_HI;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= S_CNT_HI;
      cnt_hi_reg   <= '0;
      last_idx_reg <= '0;
      addr_reg     <= '0;
      mem_addr_reg <= '0;
      mem_din_reg  <= '0;
      cpu_run_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      // Registered from the state rather than the next state: cpu_run rises
      // one cycle after the final write has landed in memory, and drops as
      // soon as a reload is requested.
      cpu_run_reg <= (state_reg == S_DONE) && !load_req;
      if (xfer && (state_reg == S_CNT_HI))
        cnt_hi_reg <= rx_data;
      if (asm_clear) begin
        last_idx_reg <= count_in - CNT_W'(1);
        addr_reg     <= '0;
      end
      // Capture address and data on the 4th byte so both are stable
      // throughout the S_WRITE cycle and held afterwards.
      if (asm_done) begin
        mem_din_reg  <= DATA_W'(asm_word);
        mem_addr_reg <= addr_reg;
      end
      // The last word ends the load, so a full-memory load never wraps.
      if ((state_reg == S_WRITE) && !is_last)
        addr_reg <= addr_reg + ADDR_W'(1);
    end
  end

  assign rx_ready = (state_reg == S_CNT_HI) || (state_reg == S_CNT_LO) ||
                    (state_reg == S_DATA);
  assign mem_we   = (state_reg == S_WRITE);
  assign mem_addr = mem_addr_reg;
  assign mem_din  = mem_din_reg;
  assign cpu_run  = cpu_run_reg;
  assign load_err = (state_reg == S_ERR);

endmodule

// File: tb/tb_instr_mem_loader.sv
module tb_instr_mem_loader;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;
  localparam int MEM_WORDS = 1 << ADDR_W;

  logic              clock = 1'b0;
  logic              reset_n = 1'b0;
  logic [7:0]        rx_data = 8'h00;
  logic              rx_valid = 1'b0;
  logic              load_req = 1'b0;
  logic              rx_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_din;
  logic              cpu_run;
  logic              load_err;

  instr_mem_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .load_req (load_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_din  (mem_din),
    .cpu_run  (cpu_run),
    .load_err (load_err)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // ---------------- monitor: observed transfers, writes, cpu_run edges ---
  logic [7:0]  tx_q[$];          // byte stream of the current scenario
  int          xfer_cyc_q[$];    // cycle in which each byte was accepted
  int          we_addr_q[$];
  logic [31:0] we_data_q[$];
  int          we_cyc_q[$];
  int          cpu_rise_q[$];
  int          we_ready_viol = 0;
  int          we_adjacent = 0;
  logic        prev_we = 1'b0;
  logic        prev_run = 1'b0;

  always begin
    @(negedge clock);
    #2;
    if (reset_n) begin
      if (rx_valid && rx_ready) xfer_cyc_q.push_back(cyc);
      if (mem_we) begin
        we_addr_q.push_back(int'(mem_addr));
        we_data_q.push_back(mem_din);
        we_cyc_q.push_back(cyc);
        if (rx_ready) we_ready_viol++;
        if (prev_we) we_adjacent++;
      end
      if (cpu_run && !prev_run) cpu_rise_q.push_back(cyc);
    end
    prev_we  = mem_we;
    prev_run = cpu_run;
  end

  task automatic clear_mon();
    xfer_cyc_q.delete();
    we_addr_q.delete();
    we_data_q.delete();
    we_cyc_q.delete();
    cpu_rise_q.delete();
    we_ready_viol = 0;
    we_adjacent = 0;
  endtask

  // ---------------- reference model: words implied by the stream --------
  function automatic logic [31:0] exp_word(int i);
    return {tx_q[2+4*i], tx_q[3+4*i], tx_q[4+4*i], tx_q[5+4*i]};
  endfunction

  // ---------------- drivers ----------------------------------------------
  task automatic send_byte(input logic [7:0] b, input int gap);
    int guard;
    repeat (gap) begin
      @(negedge clock);
      rx_valid = 1'b0;
    end
    @(negedge clock);
    rx_valid = 1'b1;
    rx_data  = b;
    guard = 0;
    while (!rx_ready && guard < 200) begin
      @(negedge clock);
      guard++;
    end
    if (guard >= 200) begin
      errors++;
      $display("FAIL rx_ready_timeout: byte %h not accepted, got rx_ready=0 required 1", b);
    end
    @(posedge clock);
  endtask

  task automatic send_stream(input int max_gap);
    foreach (tx_q[i]) begin
      int gap;
      gap = (max_gap > 0 && $urandom_range(0, 3) == 0) ? $urandom_range(1, max_gap) : 0;
      send_byte(tx_q[i], gap);
    end
    @(negedge clock);
    rx_valid = 1'b0;
  endtask

  task automatic pulse_load_req(output logic run_after);
    @(negedge clock);
    load_req = 1'b1;
    @(negedge clock);
    load_req = 1'b0;
    #1;
    run_after = cpu_run;
  endtask

  task automatic wait_cpu_run(input string name, input int max_cycles);
    int n = 0;
    while (!cpu_run && n < max_cycles) begin
      @(negedge clock);
      n++;
    end
    checks++;
    if (!cpu_run) begin
      errors++;
      $display("FAIL %s_cpu_run_timeout: got cpu_run=0 required 1 within %0d cycles", name, max_cycles);
    end
    repeat (2) @(negedge clock);
  endtask

  task automatic make_stream(input int n, input int n_words_data);
    tx_q.delete();
    tx_q.push_back(8'(n >> 8));
    tx_q.push_back(8'(n));
    repeat (4 * n_words_data) tx_q.push_back(8'($urandom_range(0, 255)));
  endtask

  // Compares every observed write against the expected program image.
  task automatic check_writes(input string name, input int n);
    checks++;
    if (we_addr_q.size() != n) begin
      errors++;
      $display("FAIL %s_write_count: got %0d required %0d", name, we_addr_q.size(), n);
    end
    for (int i = 0; i < n && i < we_addr_q.size(); i++) begin
      checks++;
      if (we_addr_q[i] != i || we_data_q[i] !== exp_word(i)) begin
        errors++;
        $display("FAIL %s_write[%0d]: got @%0d=%h required @%0d=%h",
                 name, i, we_addr_q[i], we_data_q[i], i, exp_word(i));
      end
      // 4th byte of word i is stream byte 5+4i; its write follows one cycle later
      checks++;
      if (5 + 4 * i < xfer_cyc_q.size() && we_cyc_q[i] != xfer_cyc_q[5+4*i] + 1) begin
        errors++;
        $display("FAIL %s_latency[%0d]: got write cycle %0d required %0d",
                 name, i, we_cyc_q[i], xfer_cyc_q[5+4*i] + 1);
      end
    end
    checks++;
    if (we_ready_viol != 0 || we_adjacent != 0) begin
      errors++;
      $display("FAIL %s_we_shape: got rx_ready-during-write=%0d adjacent-we=%0d required 0/0",
               name, we_ready_viol, we_adjacent);
    end
    if (n > 0) begin
      checks++;
      if (cpu_rise_q.size() != 1 || cpu_rise_q[0] != we_cyc_q[we_cyc_q.size()-1] + 2) begin
        errors++;
        $display("FAIL %s_cpu_run_rise: got %0d rises first at cycle %0d required 1 at %0d",
                 name, cpu_rise_q.size(), (cpu_rise_q.size() > 0) ? cpu_rise_q[0] : -1,
                 (we_cyc_q.size() > 0) ? we_cyc_q[we_cyc_q.size()-1] + 2 : -1);
      end
    end
  endtask

  // ---------------- scenarios ---------------------------------------------
  task automatic test_reset();
    repeat (2) @(negedge clock);
    #2;
    checks++;
    if ({mem_we, cpu_run, load_err, rx_ready} !== 4'b0001 || mem_addr !== '0 || mem_din !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got we/run/err/rdy=%b%b%b%b addr=%h din=%h required 0001 0 0",
               mem_we, cpu_run, load_err, rx_ready, mem_addr, mem_din);
    end
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    #2;
    checks++;
    if (rx_ready !== 1'b1 || cpu_run !== 1'b0 || load_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: got rdy=%b run=%b err=%b required 1 0 0", rx_ready, cpu_run, load_err);
    end
  endtask

  task automatic test_basic();
    clear_mon();
    tx_q = '{8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h23, 8'h45, 8'h67};
    send_stream(0);
    wait_cpu_run("basic", 20);
    check_writes("basic", 2);
    checks++;
    if (we_cyc_q.size() == 2 && we_cyc_q[1] - we_cyc_q[0] != 5) begin
      errors++;
      $display("FAIL basic_throughput: got %0d cycles between writes required 5", we_cyc_q[1] - we_cyc_q[0]);
    end
    $display("basic: writes=%0d cpu_run=%b", we_addr_q.size(), cpu_run);
  endtask

  task automatic test_zero_count();
    logic run_after;
    pulse_load_req(run_after);
    clear_mon();
    tx_q = '{8'h00, 8'h00};
    send_stream(0);
    wait_cpu_run("zero", 10);
    checks++;
    if (we_addr_q.size() != 0 || load_err !== 1'b0) begin
      errors++;
      $display("FAIL zero_count: got writes=%0d err=%b required 0 0", we_addr_q.size(), load_err);
    end
    $display("zero_count: cpu_run=%b", cpu_run);
  endtask

  task automatic test_overflow();
    logic run_after;
    pulse_load_req(run_after);
    clear_mon();
    tx_q = '{8'h04, 8'h01};
    send_stream(0);
    repeat (2) @(negedge clock);
    #2;
    checks++;
    if (load_err !== 1'b1 || rx_ready !== 1'b0 || cpu_run !== 1'b0 || we_addr_q.size() != 0) begin
      errors++;
      $display("FAIL overflow_err: got err=%b rdy=%b run=%b writes=%0d required 1 0 0 0",
               load_err, rx_ready, cpu_run, we_addr_q.size());
    end
    pulse_load_req(run_after);
    #2;
    checks++;
    if (load_err !== 1'b0 || rx_ready !== 1'b1 || cpu_run !== 1'b0) begin
      errors++;
      $display("FAIL overflow_recover: got err=%b rdy=%b run=%b required 0 1 0", load_err, rx_ready, cpu_run);
    end
    $display("overflow: recovered err=%b", load_err);
  endtask

  task automatic test_full_memory();
    clear_mon();
    make_stream(MEM_WORDS, MEM_WORDS);
    send_stream(3);
    wait_cpu_run("full", 20);
    repeat (5) @(negedge clock);
    check_writes("full", MEM_WORDS);
    $display("full_memory: writes=%0d last_addr=%0d", we_addr_q.size(),
             (we_addr_q.size() > 0) ? we_addr_q[we_addr_q.size()-1] : -1);
  endtask

  task automatic test_reload();
    logic run_after;
    pulse_load_req(run_after);
    checks++;
    if (run_after !== 1'b0) begin
      errors++;
      $display("FAIL reload_cpu_run_fall: got cpu_run=%b required 0", run_after);
    end
    clear_mon();
    make_stream(1, 1);
    send_stream(2);
    wait_cpu_run("reload", 20);
    check_writes("reload", 1);
    $display("reload: word=%h cpu_run=%b", (we_data_q.size() > 0) ? we_data_q[0] : 32'hx, cpu_run);
  endtask

  task automatic test_reset_mid_load();
    logic run_after;
    pulse_load_req(run_after);
    clear_mon();
    make_stream(2, 2);
    tx_q = tx_q[0:7];             // header plus 6 data bytes only
    send_stream(0);
    checks++;
    if (we_addr_q.size() != 1 || we_data_q[0] !== exp_word(0)) begin
      errors++;
      $display("FAIL midload_first_word: got writes=%0d required 1 with %h", we_addr_q.size(), exp_word(0));
    end
    @(negedge clock);
    #1;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({mem_we, cpu_run, load_err, rx_ready} !== 4'b0001 || mem_addr !== '0 || mem_din !== '0) begin
      errors++;
      $display("FAIL midload_reset_outputs: got we/run/err/rdy=%b%b%b%b addr=%h din=%h required 0001 0 0",
               mem_we, cpu_run, load_err, rx_ready, mem_addr, mem_din);
    end
    @(negedge clock);
    reset_n = 1'b1;
    clear_mon();
    make_stream(1, 1);
    send_stream(1);
    wait_cpu_run("after_reset", 20);
    check_writes("after_reset", 1);
    $display("reset_mid_load: reload word=%h", (we_data_q.size() > 0) ? we_data_q[0] : 32'hx);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_count();
    test_overflow();
    test_full_memory();
    test_reload();
    test_reset_mid_load();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_mem_loader.md
# instr_mem_loader

Boot-time writer for the instruction memory that the fetch stage only ever reads. It receives a byte stream (from the UART receiver), assembles big-endian 32-bit words and drives the write side of the instruction memory, `wea`/`addra`/`dina`, from address 0 upward. It holds the CPU stalled (`cpu_run` low) until the whole program is written, then releases it. It sits between the UART RX and the instruction memory write port, in front of the fetch stage.

## Interface
Parameters:
- `ADDR_W`, default 10: instruction memory address width (words).
- `DATA_W`, default 32: instruction width; fixed at 4 bytes.

Ports:
- `clock`, in, 1: single system clock; all state changes on its rising edge.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `rx_data`, in, 8: incoming byte.
- `rx_valid`, in, 1: `rx_data` valid this cycle.
- `rx_ready`, out, 1: loader accepts a byte this cycle. A byte transfers when `rx_valid && rx_ready`.
- `load_req`, in, 1: restart a load from `S_DONE` or `S_ERR`.
- `mem_we`, out, 1: instruction memory write enable; one-cycle pulse per word.
- `mem_addr`, out, ADDR_W: write address.
- `mem_din`, out, DATA_W: write data.
- `cpu_run`, out, 1: high when the program is loaded; low holds the PC and pipeline.
- `load_err`, out, 1: high in `S_ERR`.

## Operation
- Stream format:
  - 2-byte word count N, big-endian (high byte first).
  - Then 4·N bytes forming N big-endian words, first byte in bits [31:24].
- FSM states: `S_CNT_HI`, `S_CNT_LO`, `S_DATA`, `S_WRITE`, `S_DONE`, `S_ERR`.
- `S_CNT_HI`: on transfer, latch the count high byte → `S_CNT_LO`.
- `S_CNT_LO`: on transfer, latch the low byte and evaluate N:
  - N == 0 → `S_DONE`.
  - N > 2^ADDR_W → `S_ERR`.
  - otherwise clear the byte counter and word address → `S_DATA`.
- `S_DATA`: shift each transferred byte into the word register.
  - On the 4th byte, byte counter wraps 3→0 → `S_WRITE`.
- `S_WRITE`: exactly one cycle.
  - `mem_we`=1, `mem_addr`=word address, `mem_din`=assembled word.
  - If word address == N−1 → `S_DONE`; else address +1 → `S_DATA`.
- `S_DONE`: `cpu_run`=1. `load_req` → `S_CNT_HI` with `cpu_run` dropping the next cycle.
- `S_ERR`: `load_err`=1, `cpu_run`=0. `load_req` → `S_CNT_HI`.
- `rx_ready` is 1 in `S_CNT_HI`, `S_CNT_LO` and `S_DATA`; 0 in `S_WRITE`, `S_DONE` and `S_ERR`. Bytes offered while `rx_ready`=0 are not consumed; the source must hold them.
- Word address is an ADDR_W-bit counter. N == 2^ADDR_W is legal and fills memory exactly; the address never wraps because the last write ends the load.
- `load_req` outside `S_DONE`/`S_ERR` is ignored.

## Timing
- Reset (asynchronous assert, synchronous release):
  - state `S_CNT_HI`.
  - `mem_we`=0, `mem_addr`=0, `mem_din`=0.
  - `cpu_run`=0, `load_err`=0, `rx_ready`=1 on the first cycle after release.
- Latency: 4th byte of a word transferred at edge t → `mem_we` high for the cycle following t. Write lands at edge t+1.
- Sustained throughput: 4 bytes per 5 cycles.
- Last write at edge t → `cpu_run`=1 from the cycle after edge t+1, so the memory holds the final word before the fetch stage reads.
- Reset mid-load: abort immediately. Already-written words stay in memory; `cpu_run` stays 0 until a complete reload.
- `mem_addr`/`mem_din` are registered outputs and hold their last values outside `S_WRITE`. Only `mem_we` qualifies them.

## Structure
- Shared package:
  - state enum.
  - `BYTES_PER_WORD`=4.
  - `CNT_W`=16.
  - loader max-word constant 2^ADDR_W.
- One natural sub-module, `word_assembler`: 4-byte shift register plus 2-bit byte counter, with `clear`/`shift_en` inputs and `word`/`word_done` outputs. The FSM, address counter and count compare stay in the top module.

## Test plan
- Bytes 00 02 | DE AD BE EF | 01 23 45 67 with `rx_valid` held high:
  - writes 0xDEADBEEF @0, then 0x01234567 @1, each a single-cycle `mem_we`.
  - `rx_ready` low during each `S_WRITE`.
  - `cpu_run` rises 1 cycle after the second write.
- Count 00 00 → `S_DONE` directly; no `mem_we`; `cpu_run`=1.
- Count 04 01 (1025 > 1024) → `load_err`=1, `rx_ready`=0, `cpu_run`=0. Then `load_req` → `S_CNT_HI`, `load_err`=0.
- Count 04 00 with 4096 random bytes and random `rx_valid` gaps:
  - addresses 0..1023 each written exactly once with the expected words.
  - no address wrap.
- `reset_n` pulsed low after 6 data bytes:
  - all outputs at reset values immediately.
  - a subsequent full 1-word load writes @0 correctly.
- From `S_DONE`, `load_req` pulse with a new 1-word stream:
  - `cpu_run` falls the next cycle.
  - the new word is written @0.
  - `cpu_run` rises again after the write.
